// File: rtl/time_lcd_writer.sv
// Snapshots sec/min/hour on change or refresh, converts each field to two ASCII
// digits by repeated subtraction and streams "HH:MM:SS" over a valid/ready link.
module time_lcd_writer #(
    parameter logic [6:0] COL_BASE = 7'h00,
    parameter logic [7:0] SEP_CHAR = 8'h3A
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hour,
    input  logic       refresh,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic [6:0] char_addr,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {StIdle, StConv, StSend} state_e;

    state_e     state_q, state_d;
    logic       first_q, first_d;
    logic [5:0] snap_sec_q, snap_sec_d;
    logic [5:0] snap_min_q, snap_min_d;
    logic [5:0] snap_hour_q, snap_hour_d;
    logic [5:0] rem_sec_q, rem_sec_d;
    logic [5:0] rem_min_q, rem_min_d;
    logic [5:0] rem_hour_q, rem_hour_d;
    logic [2:0] tens_sec_q, tens_sec_d;
    logic [2:0] tens_min_q, tens_min_d;
    logic [2:0] tens_hour_q, tens_hour_d;
    logic [2:0] index_q, index_d;
    logic       frame_done_q, frame_done_d;

    logic       time_changed;
    logic       conv_done;

    assign time_changed = (sec != snap_sec_q) || (min != snap_min_q) || (hour != snap_hour_q);
    assign conv_done    = (rem_sec_q < 6'd10) && (rem_min_q < 6'd10) && (rem_hour_q < 6'd10);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            first_q      <= 1'b1;
            snap_sec_q   <= '0;
            snap_min_q   <= '0;
            snap_hour_q  <= '0;
            rem_sec_q    <= '0;
            rem_min_q    <= '0;
            rem_hour_q   <= '0;
            tens_sec_q   <= '0;
            tens_min_q   <= '0;
            tens_hour_q  <= '0;
            index_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            snap_sec_q   <= snap_sec_d;
            snap_min_q   <= snap_min_d;
            snap_hour_q  <= snap_hour_d;
            rem_sec_q    <= rem_sec_d;
            rem_min_q    <= rem_min_d;
            rem_hour_q   <= rem_hour_d;
            tens_sec_q   <= tens_sec_d;
            tens_min_q   <= tens_min_d;
            tens_hour_q  <= tens_hour_d;
            index_q      <= index_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        snap_sec_d   = snap_sec_q;
        snap_min_d   = snap_min_q;
        snap_hour_d  = snap_hour_q;
        rem_sec_d    = rem_sec_q;
        rem_min_d    = rem_min_q;
        rem_hour_d   = rem_hour_q;
        tens_sec_d   = tens_sec_q;
        tens_min_d   = tens_min_q;
        tens_hour_d  = tens_hour_q;
        index_d      = index_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (time_changed || refresh || first_q) begin
                    snap_sec_d  = sec;
                    snap_min_d  = min;
                    snap_hour_d = hour;
                    rem_sec_d   = sec;
                    rem_min_d   = min;
                    rem_hour_d  = hour;
                    tens_sec_d  = '0;
                    tens_min_d  = '0;
                    tens_hour_d = '0;
                    first_d     = 1'b0;
                    state_d     = StConv;
                end
            end
            StConv: begin
                // All three fields subtract in lockstep; the slowest field sets the length.
                if (rem_sec_q >= 6'd10) begin
                    rem_sec_d  = rem_sec_q - 6'd10;
                    tens_sec_d = tens_sec_q + 3'd1;
                end
                if (rem_min_q >= 6'd10) begin
                    rem_min_d  = rem_min_q - 6'd10;
                    tens_min_d = tens_min_q + 3'd1;
                end
                if (rem_hour_q >= 6'd10) begin
                    rem_hour_d  = rem_hour_q - 6'd10;
                    tens_hour_d = tens_hour_q + 3'd1;
                end
                if (conv_done) begin
                    index_d = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (char_ready) begin
                    index_d = index_q + 3'd1;
                    if (index_q == 3'd7) begin
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        char_data = 8'h00;
        if (state_q == StSend) begin
            case (index_q)
                3'd0:    char_data = 8'h30 + {5'd0, tens_hour_q};
                3'd1:    char_data = 8'h30 + {4'd0, rem_hour_q[3:0]};
                3'd2:    char_data = SEP_CHAR;
                3'd3:    char_data = 8'h30 + {5'd0, tens_min_q};
                3'd4:    char_data = 8'h30 + {4'd0, rem_min_q[3:0]};
                3'd5:    char_data = SEP_CHAR;
                3'd6:    char_data = 8'h30 + {5'd0, tens_sec_q};
                default: char_data = 8'h30 + {4'd0, rem_sec_q[3:0]};
            endcase
        end
    end

    assign char_valid = (state_q == StSend);
    assign char_addr  = COL_BASE + {4'd0, index_q};
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_time_lcd_writer.sv
// Directed bench for time_lcd_writer: scoreboard of expected characters checked
// on every accepted transfer, plus latency, hold, refresh and reset checks.
module tb_time_lcd_writer;

    localparam logic [6:0] COL_BASE = 7'h00;
    localparam logic [7:0] SEP      = 8'h3A;

    logic       clock = 1'b0;
    logic       resetn;
    logic [5:0] sec, min, hour;
    logic       refresh;
    logic       char_ready;
    logic       char_valid;
    logic [7:0] char_data;
    logic [6:0] char_addr;
    logic       busy;
    logic       frame_done;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          ready_mode = 0;
    logic [14:0] exp_q[$];
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    logic [14:0] prev_word = '0;

    time_lcd_writer #(.COL_BASE(COL_BASE), .SEP_CHAR(SEP)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .refresh    (refresh),
        .char_ready (char_ready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_addr  (char_addr),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] dig(input int v);
        return 8'(32'h30 + v);
    endfunction

    function automatic void push_frame(input int h, input int m, input int s);
        logic [7:0] c [8];
        c[0] = dig(h / 10); c[1] = dig(h % 10); c[2] = SEP;
        c[3] = dig(m / 10); c[4] = dig(m % 10); c[5] = SEP;
        c[6] = dig(s / 10); c[7] = dig(s % 10);
        for (int i = 0; i < 8; i++) exp_q.push_back({7'(COL_BASE + i), c[i]});
    endfunction

    // Ready source: 0 = always ready, 1 = repeating 1-0-0-1 pattern.
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        char_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 1) begin
                char_ready = pat[k % 4];
                k++;
            end else begin
                char_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!resetn) begin
            prev_valid <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(char_valid), 32'd1);
                check("hold_word", 32'({char_addr, char_data}), 32'(prev_word));
            end
            if (char_valid && char_ready) begin
                check("char_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("char", 32'({char_addr, char_data}), 32'(exp_q.pop_front()));
            end
            if (frame_done) begin
                done_cnt <= done_cnt + 1;
                check("done_width", 32'(prev_done), 32'd0);
            end
            prev_valid <= char_valid;
            prev_ready <= char_ready;
            prev_word  <= {char_addr, char_data};
            prev_done  <= frame_done;
        end
    end

    // Caller sits just before the capture edge; counts CONV cycles until char_valid.
    task automatic start_measure(input int exp_conv, input string tag);
        int n;
        n = 0;
        @(posedge clock);
        #1 refresh = 1'b0;
        @(negedge clock);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!char_valid && n < 40) begin
            n++;
            @(negedge clock);
        end
        check({tag, "_conv_cycles"}, 32'(n), 32'(exp_conv));
    endtask

    task automatic wait_done(input string tag, input int left);
        int n;
        n = 0;
        while (!frame_done && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, 32'(frame_done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'(left));
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int b;
        b = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (busy || char_valid) b++;
        end
        check({tag, "_idle"}, 32'(b), 32'd0);
    endtask

    initial begin
        resetn  = 1'b0;
        sec     = 6'd0;
        min     = 6'd0;
        hour    = 6'd0;
        refresh = 1'b0;
        @(negedge clock);
        check("rst_valid", 32'(char_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_addr", 32'(char_addr), 32'(COL_BASE));
        check("rst_data", 32'(char_data), 32'h00);

        // First frame after reset release.
        push_frame(0, 0, 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        start_measure(1, "f0");
        wait_done("f0", 0);
        idle_check(10, "f0");

        hour = 6'd23; min = 6'd59; sec = 6'd59;
        push_frame(23, 59, 59);
        start_measure(6, "f1");
        wait_done("f1", 0);

        // Back-pressure with ready toggling.
        ready_mode = 1;
        hour = 6'd12; min = 6'd34; sec = 6'd56;
        push_frame(12, 34, 56);
        start_measure(6, "f2");
        wait_done("f2", 0);
        ready_mode = 0;

        // Seconds change while index 3 is on the bus.
        sec = 6'd5;
        push_frame(12, 34, 5);
        start_measure(4, "f3");
        repeat (3) @(posedge clock);
        #1 sec = 6'd6;
        push_frame(12, 34, 6);
        wait_done("f3", 8);
        start_measure(4, "f4");
        wait_done("f4", 0);

        // Refresh in IDLE resends; refresh during SEND is ignored.
        idle_check(5, "f4");
        push_frame(12, 34, 6);
        refresh = 1'b1;
        start_measure(4, "f5");
        refresh = 1'b1;
        repeat (2) @(posedge clock);
        #1 refresh = 1'b0;
        wait_done("f5", 0);
        idle_check(20, "f5");

        // Reset while index 4 is on the bus.
        hour = 6'd7; min = 6'd8; sec = 6'd9;
        push_frame(7, 8, 9);
        start_measure(1, "f6");
        repeat (4) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("abort_valid", 32'(char_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_left", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        push_frame(7, 8, 9);
        @(posedge clock);
        #1 resetn = 1'b1;
        start_measure(1, "f7");
        wait_done("f7", 0);
        idle_check(10, "f7");

        check("frame_count", 32'(done_cnt), 32'd7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
